// File: rtl/servo_scan_sequencer.sv
// Raster-scan sequencer: steps yaw/pitch duty words across a grid on PWM frame
// boundaries, settles, then handshakes one LiDAR sample per grid point.
module servo_scan_sequencer #(
  parameter int unsigned FRAME_CYCLES = 2000001,
  parameter int unsigned DUTY_MIN     = 100000,
  parameter int unsigned DUTY_MAX     = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] yaw_start,
  input  logic [31:0] yaw_stop,
  input  logic [31:0] yaw_step,
  input  logic [31:0] pitch_start,
  input  logic [31:0] pitch_stop,
  input  logic [31:0] pitch_step,
  input  logic [7:0]  settle_frames,
  input  logic        sample_ack,
  output logic [31:0] yaw_duty_o,
  output logic [31:0] pitch_duty_o,
  output logic        sample_req_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] point_idx_o
);

  localparam int          CW         = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);
  localparam logic [31:0] DUTY_LO    = 32'(DUTY_MIN);
  localparam logic [31:0] DUTY_HI    = 32'(DUTY_MAX);
  localparam logic [31:0] DUTY_MID   = 32'((DUTY_MIN + DUTY_MAX) / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_SETTLE, S_SAMPLE, S_STEP, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [31:0]     yaw_start_q, yaw_start_d, yaw_stop_q, yaw_stop_d, yaw_step_q, yaw_step_d;
  logic [31:0]     pitch_start_q, pitch_start_d, pitch_stop_q, pitch_stop_d;
  logic [31:0]     pitch_step_q, pitch_step_d;
  logic [7:0]      settle_cfg_q, settle_cfg_d, settle_cnt_q, settle_cnt_d;
  logic [31:0]     yaw_tgt_q, yaw_tgt_d, pitch_tgt_q, pitch_tgt_d;
  logic [31:0]     yaw_duty_q, yaw_duty_d, pitch_duty_q, pitch_duty_d;
  logic            req_q, req_d;
  logic [15:0]     point_idx_q, point_idx_d;

  logic            frame_tick;
  logic [32:0]     yaw_sum, pitch_sum;
  logic            yaw_adv, pitch_adv;

  function automatic logic [31:0] clamp_duty(input logic [31:0] v);
    if (v < DUTY_LO)      return DUTY_LO;
    else if (v > DUTY_HI) return DUTY_HI;
    else                  return v;
  endfunction

  assign frame_tick = (frame_cnt_q == FRAME_LAST);

  // A zero step would otherwise satisfy tgt+0 <= stop forever, so it blocks advancing.
  assign yaw_sum   = {1'b0, yaw_tgt_q} + {1'b0, yaw_step_q};
  assign pitch_sum = {1'b0, pitch_tgt_q} + {1'b0, pitch_step_q};
  assign yaw_adv   = !yaw_sum[32] && (yaw_sum[31:0] <= yaw_stop_q) && (yaw_step_q != 32'd0);
  assign pitch_adv = !pitch_sum[32] && (pitch_sum[31:0] <= pitch_stop_q) && (pitch_step_q != 32'd0);

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_tick ? '0 : frame_cnt_q + 1'b1;
    yaw_start_d   = yaw_start_q;
    yaw_stop_d    = yaw_stop_q;
    yaw_step_d    = yaw_step_q;
    pitch_start_d = pitch_start_q;
    pitch_stop_d  = pitch_stop_q;
    pitch_step_d  = pitch_step_q;
    settle_cfg_d  = settle_cfg_q;
    settle_cnt_d  = settle_cnt_q;
    yaw_tgt_d     = yaw_tgt_q;
    pitch_tgt_d   = pitch_tgt_q;
    yaw_duty_d    = yaw_duty_q;
    pitch_duty_d  = pitch_duty_q;
    req_d         = 1'b0;
    point_idx_d   = point_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          yaw_start_d   = yaw_start;
          yaw_stop_d    = yaw_stop;
          yaw_step_d    = yaw_step;
          pitch_start_d = pitch_start;
          pitch_stop_d  = pitch_stop;
          pitch_step_d  = pitch_step;
          settle_cfg_d  = settle_frames;
          yaw_tgt_d     = yaw_start;
          pitch_tgt_d   = pitch_start;
          point_idx_d   = '0;
          state_d       = S_MOVE;
        end
      end
      S_MOVE: begin
        if (frame_tick) begin
          yaw_duty_d   = clamp_duty(yaw_tgt_q);
          pitch_duty_d = clamp_duty(pitch_tgt_q);
          settle_cnt_d = '0;
          state_d      = (settle_cfg_q == 8'd0) ? S_SAMPLE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (frame_tick) begin
          if (settle_cnt_q == settle_cfg_q - 8'd1) state_d = S_SAMPLE;
          else                                     settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      S_SAMPLE: begin
        // Only an ack seen while the request is visible completes the handshake.
        if (sample_ack && req_q) begin
          if (point_idx_q != 16'hFFFF) point_idx_d = point_idx_q + 16'd1;
          state_d = S_STEP;
        end else begin
          req_d = 1'b1;
        end
      end
      S_STEP: begin
        state_d = S_MOVE;
        if (yaw_adv) begin
          yaw_tgt_d = yaw_sum[31:0];
        end else begin
          yaw_tgt_d = yaw_start_q;
          if (pitch_adv) pitch_tgt_d = pitch_sum[31:0];
          else           state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      req_d        = 1'b0;
      point_idx_d  = point_idx_q;
      yaw_duty_d   = yaw_duty_q;
      pitch_duty_d = pitch_duty_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      frame_cnt_q   <= '0;
      yaw_start_q   <= '0;
      yaw_stop_q    <= '0;
      yaw_step_q    <= '0;
      pitch_start_q <= '0;
      pitch_stop_q  <= '0;
      pitch_step_q  <= '0;
      settle_cfg_q  <= '0;
      settle_cnt_q  <= '0;
      yaw_tgt_q     <= '0;
      pitch_tgt_q   <= '0;
      yaw_duty_q    <= DUTY_MID;
      pitch_duty_q  <= DUTY_MID;
      req_q         <= 1'b0;
      point_idx_q   <= '0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      yaw_start_q   <= yaw_start_d;
      yaw_stop_q    <= yaw_stop_d;
      yaw_step_q    <= yaw_step_d;
      pitch_start_q <= pitch_start_d;
      pitch_stop_q  <= pitch_stop_d;
      pitch_step_q  <= pitch_step_d;
      settle_cfg_q  <= settle_cfg_d;
      settle_cnt_q  <= settle_cnt_d;
      yaw_tgt_q     <= yaw_tgt_d;
      pitch_tgt_q   <= pitch_tgt_d;
      yaw_duty_q    <= yaw_duty_d;
      pitch_duty_q  <= pitch_duty_d;
      req_q         <= req_d;
      point_idx_q   <= point_idx_d;
    end
  end

  assign yaw_duty_o   = yaw_duty_q;
  assign pitch_duty_o = pitch_duty_q;
  assign sample_req_o = req_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign point_idx_o  = point_idx_q;

endmodule

// File: tb/tb_servo_scan_sequencer.sv
// Bench for servo_scan_sequencer with a 10-cycle frame; expected grid points
// are queued at scan start and popped as each sample request appears.
module tb_servo_scan_sequencer;

  localparam int FRAME = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] yaw_start = '0, yaw_stop = '0, yaw_step = '0;
  logic [31:0] pitch_start = '0, pitch_stop = '0, pitch_step = '0;
  logic [7:0]  settle_frames = '0;
  logic        sample_ack = 1'b0;
  logic [31:0] yaw_duty_o, pitch_duty_o;
  logic        sample_req_o, busy_o, done_o;
  logic [15:0] point_idx_o;

  servo_scan_sequencer #(.FRAME_CYCLES(FRAME)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .yaw_start(yaw_start), .yaw_stop(yaw_stop), .yaw_step(yaw_step),
    .pitch_start(pitch_start), .pitch_stop(pitch_stop), .pitch_step(pitch_step),
    .settle_frames(settle_frames), .sample_ack(sample_ack),
    .yaw_duty_o(yaw_duty_o), .pitch_duty_o(pitch_duty_o),
    .sample_req_o(sample_req_o), .busy_o(busy_o), .done_o(done_o),
    .point_idx_o(point_idx_o)
  );

  always #5 clk = ~clk;

  // Reference frame position: 0 right after each frame_tick edge.
  int tb_cnt = 0;
  always @(posedge clk) begin
    if (reset) tb_cnt <= 0;
    else       tb_cnt <= (tb_cnt == FRAME - 1) ? 0 : tb_cnt + 1;
  end

  int done_total = 0;
  always @(negedge clk) if (done_o === 1'b1) done_total <= done_total + 1;

  int compared = 0;
  int mismatched = 0;
  logic [63:0] exp_q[$];
  logic [31:0] prev_yaw, prev_pitch;
  int ticks_since, cyc_since, misaligned;

  task automatic observe();
    if (yaw_duty_o !== prev_yaw || pitch_duty_o !== prev_pitch) begin
      if (tb_cnt != 0) misaligned++;
      prev_yaw    = yaw_duty_o;
      prev_pitch  = pitch_duty_o;
      ticks_since = 0;
      cyc_since   = 0;
    end else begin
      cyc_since++;
      if (tb_cnt == 0) ticks_since++;
    end
  endtask

  task automatic step_cycle();
    @(negedge clk);
    observe();
  endtask

  task automatic wait_req(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step_cycle();
      if (sample_req_o === 1'b1) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step_cycle();
      if (busy_o === 1'b0) begin got = 1'b1; break; end
    end
  endtask

  task automatic send_ack();
    step_cycle();
    step_cycle();
    sample_ack = 1'b1;
    step_cycle();
    sample_ack = 1'b0;
  endtask

  task automatic start_scan(input logic [31:0] ys, input logic [31:0] ye, input logic [31:0] yd,
                            input logic [31:0] ps, input logic [31:0] pe, input logic [31:0] pd,
                            input logic [7:0] st);
    yaw_start = ys; yaw_stop = ye; yaw_step = yd;
    pitch_start = ps; pitch_stop = pe; pitch_step = pd;
    settle_frames = st;
    start = 1'b1;
    step_cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    compared++; if (yaw_duty_o !== 32'd150000) begin mismatched++; $display("[TB] FAIL reset_yaw: got %0d expected 150000", yaw_duty_o); end
    compared++; if (pitch_duty_o !== 32'd150000) begin mismatched++; $display("[TB] FAIL reset_pitch: got %0d expected 150000", pitch_duty_o); end
    compared++; if (sample_req_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_req: got %b expected 0", sample_req_o); end
    compared++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy_done: got %b%b expected 00", busy_o, done_o); end
    compared++; if (point_idx_o !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_idx: got %0d expected 0", point_idx_o); end
    reset = 1'b0;
    prev_yaw = 32'd150000; prev_pitch = 32'd150000;
    ticks_since = 0; cyc_since = 0; misaligned = 0;
  endtask

  task automatic test_full_grid();
    bit got;
    logic [63:0] e;
    int base = done_total;
    misaligned = 0;
    for (int p = 0; p < 2; p++)
      for (int y = 0; y < 3; y++)
        exp_q.push_back({32'(120000 + 10000 * y), 32'(150000 + 10000 * p)});
    start_scan(120000, 140000, 10000, 150000, 160000, 10000, 2);
    compared++; if (busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL grid_busy: got %b expected 1", busy_o); end
    for (int n = 0; n < 6; n++) begin
      wait_req(200, got);
      compared++; if (!got) begin mismatched++; $display("[TB] FAIL grid_req_timeout: point %0d got none expected req", n); break; end
      e = exp_q.pop_front();
      compared++; if (yaw_duty_o !== e[63:32]) begin mismatched++; $display("[TB] FAIL grid_yaw: point %0d got %0d expected %0d", n, yaw_duty_o, e[63:32]); end
      compared++; if (pitch_duty_o !== e[31:0]) begin mismatched++; $display("[TB] FAIL grid_pitch: point %0d got %0d expected %0d", n, pitch_duty_o, e[31:0]); end
      compared++; if (ticks_since < 2) begin mismatched++; $display("[TB] FAIL grid_settle: point %0d got %0d ticks expected >=2", n, ticks_since); end
      send_ack();
      compared++; if (sample_req_o !== 1'b0) begin mismatched++; $display("[TB] FAIL grid_req_drop: got %b expected 0", sample_req_o); end
    end
    wait_idle(200, got);
    compared++; if (!got) begin mismatched++; $display("[TB] FAIL grid_idle_timeout: busy got %b expected 0", busy_o); end
    compared++; if (done_total - base != 1) begin mismatched++; $display("[TB] FAIL grid_done: got %0d pulses expected 1", done_total - base); end
    compared++; if (point_idx_o !== 16'd6) begin mismatched++; $display("[TB] FAIL grid_idx: got %0d expected 6", point_idx_o); end
    compared++; if (misaligned != 0) begin mismatched++; $display("[TB] FAIL grid_align: got %0d off-tick changes expected 0", misaligned); end
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL grid_left: got %0d unserved points expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_clamp_overflow();
    bit got;
    logic [63:0] e;
    int base = done_total;
    misaligned = 0;
    exp_q.push_back({32'd100000, 32'd150000});
    exp_q.push_back({32'd200000, 32'd150000});
    start_scan(90000, 32'hFFFF_FFFF, 32'h8000_0000, 150000, 150000, 0, 1);
    for (int n = 0; n < 2; n++) begin
      wait_req(200, got);
      compared++; if (!got) begin mismatched++; $display("[TB] FAIL clamp_req_timeout: point %0d got none expected req", n); break; end
      e = exp_q.pop_front();
      compared++; if (yaw_duty_o !== e[63:32]) begin mismatched++; $display("[TB] FAIL clamp_yaw: point %0d got %0d expected %0d", n, yaw_duty_o, e[63:32]); end
      compared++; if (pitch_duty_o !== e[31:0]) begin mismatched++; $display("[TB] FAIL clamp_pitch: point %0d got %0d expected %0d", n, pitch_duty_o, e[31:0]); end
      send_ack();
    end
    wait_idle(200, got);
    compared++; if (!got || done_total - base != 1) begin mismatched++; $display("[TB] FAIL clamp_done: got %0d pulses idle=%b expected 1", done_total - base, got); end
    compared++; if (point_idx_o !== 16'd2) begin mismatched++; $display("[TB] FAIL clamp_idx: got %0d expected 2", point_idx_o); end
    compared++; if (misaligned != 0) begin mismatched++; $display("[TB] FAIL clamp_align: got %0d off-tick changes expected 0", misaligned); end
    exp_q.delete();
  endtask

  task automatic test_settle_zero();
    bit got;
    int base = done_total;
    exp_q.push_back({32'd130000, 32'd170000});
    start_scan(130000, 130000, 0, 170000, 170000, 0, 0);
    wait_req(200, got);
    compared++; if (!got) begin mismatched++; $display("[TB] FAIL zero_req_timeout: got none expected req"); end
    compared++; if (cyc_since != 1) begin mismatched++; $display("[TB] FAIL zero_req_latency: got %0d cycles expected 1", cyc_since); end
    compared++; if ({yaw_duty_o, pitch_duty_o} !== exp_q[0]) begin mismatched++; $display("[TB] FAIL zero_point: got %0d/%0d expected %0d/%0d", yaw_duty_o, pitch_duty_o, exp_q[0][63:32], exp_q[0][31:0]); end
    void'(exp_q.pop_front());
    send_ack();
    wait_idle(50, got);
    compared++; if (!got || done_total - base != 1) begin mismatched++; $display("[TB] FAIL zero_done: got %0d pulses idle=%b expected 1", done_total - base, got); end
    compared++; if (point_idx_o !== 16'd1) begin mismatched++; $display("[TB] FAIL zero_idx: got %0d expected 1", point_idx_o); end
  endtask

  task automatic test_abort();
    bit got;
    int base = done_total;
    start_scan(120000, 140000, 10000, 150000, 160000, 10000, 1);
    yaw_start = 100000;
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    wait_req(200, got);
    compared++; if (!got || yaw_duty_o !== 32'd120000) begin mismatched++; $display("[TB] FAIL abort_first_point: got yaw %0d req=%b expected 120000", yaw_duty_o, got); end
    send_ack();
    wait_req(200, got);
    compared++; if (!got || yaw_duty_o !== 32'd130000 || pitch_duty_o !== 32'd150000) begin mismatched++; $display("[TB] FAIL abort_second_point: got %0d/%0d expected 130000/150000", yaw_duty_o, pitch_duty_o); end
    sample_ack = 1'b1;
    abort = 1'b1;
    step_cycle();
    sample_ack = 1'b0;
    abort = 1'b0;
    compared++; if (busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_busy: got %b expected 0", busy_o); end
    compared++; if (sample_req_o !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_req: got %b expected 0", sample_req_o); end
    compared++; if (point_idx_o !== 16'd1) begin mismatched++; $display("[TB] FAIL abort_idx: got %0d expected 1", point_idx_o); end
    compared++; if (yaw_duty_o !== 32'd130000) begin mismatched++; $display("[TB] FAIL abort_duty_hold: got %0d expected 130000", yaw_duty_o); end
    repeat (30) step_cycle();
    compared++; if (busy_o !== 1'b0 || done_total != base) begin mismatched++; $display("[TB] FAIL abort_no_done: got busy=%b pulses=%0d expected 0/0", busy_o, done_total - base); end
  endtask

  task automatic test_stall();
    bit got;
    int bad = 0;
    int base = done_total;
    start_scan(110000, 110000, 0, 190000, 190000, 0, 1);
    wait_req(200, got);
    compared++; if (!got || yaw_duty_o !== 32'd110000 || pitch_duty_o !== 32'd190000) begin mismatched++; $display("[TB] FAIL stall_point: got %0d/%0d req=%b expected 110000/190000", yaw_duty_o, pitch_duty_o, got); end
    repeat (50 * FRAME) begin
      step_cycle();
      if (sample_req_o !== 1'b1 || yaw_duty_o !== 32'd110000 || pitch_duty_o !== 32'd190000) bad++;
    end
    compared++; if (bad != 0) begin mismatched++; $display("[TB] FAIL stall_hold: got %0d bad cycles expected 0", bad); end
    compared++; if (point_idx_o !== 16'd0) begin mismatched++; $display("[TB] FAIL stall_idx: got %0d expected 0", point_idx_o); end
    send_ack();
    wait_idle(50, got);
    compared++; if (!got || done_total - base != 1 || point_idx_o !== 16'd1) begin mismatched++; $display("[TB] FAIL stall_finish: got pulses=%0d idx=%0d expected 1/1", done_total - base, point_idx_o); end
  endtask

  initial begin
    test_reset();
    test_full_grid();
    test_clamp_overflow();
    test_settle_zero();
    test_abort();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
